// File: rtl/numlock_pkg.sv
// Shared constants for the parametrised number lock: state encoding,
// press decode on {U,Z}, and a ceiling-log2 used to size counters.
package numlock_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENTER   = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_BAD     = 3'd3;
  localparam logic [2:0] ST_OPEN    = 3'd4;
  localparam logic [2:0] ST_LOCKOUT = 3'd5;

  localparam logic [1:0] PRESS_NONE = 2'b00;
  localparam logic [1:0] PRESS_ZERO = 2'b01;
  localparam logic [1:0] PRESS_ONE  = 2'b10;
  localparam logic [1:0] PRESS_BAD  = 2'b11;

  // Never returns less than 1 so the result can always size a vector.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/numlock_timer.sv
// Down-counter shared by OPEN and LOCKOUT dwell; loaded with N-1 and
// reports done while the count sits at zero.
module numlock_timer #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
  assign done  = (count_q == '0);

endmodule

// File: rtl/numlock_param_sm.sv
// Combination lock of CODE_LEN two-button presses with loadable code,
// timed unlock and lockout after MAX_FAILS consecutive bad entries.
//
// state    | meaning
// IDLE     | no digits accepted yet, code_load honoured here
// ENTER    | partway through the code, waiting for next press
// RELEASE  | digit accepted, waiting for both buttons up
// BAD      | wrong/invalid press, waiting for both buttons up
// OPEN     | Unlock held for OPEN_CYCLES
// LOCKOUT  | Lockout held for LOCKOUT_CYCLES, inputs ignored
module numlock_param_sm
  import numlock_pkg::*;
#(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE_RESET     = 4'b1011,
  parameter int                  OPEN_CYCLES    = 6,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  LOCKOUT_CYCLES = 16,
  localparam int IDX_W  = clog2(CODE_LEN + 1),
  localparam int FAIL_W = clog2(MAX_FAILS + 1),
  localparam int CNT_W  = clog2((OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES)
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                U,
  input  logic                Z,
  input  logic [CODE_LEN-1:0] code_in,
  input  logic                code_load,
  output logic                Unlock,
  output logic                Lockout,
  output logic [2:0]          q_state,
  output logic [IDX_W-1:0]    digit_idx,
  output logic [FAIL_W-1:0]   fail_count
);

  logic [2:0]          state_q, state_d;
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;

  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_load_val;
  logic                tmr_done;
  logic [CNT_W-1:0]    tmr_count_unused;

  logic [1:0]          press;
  logic [CODE_LEN-1:0] code_shift;
  logic                exp_bit;
  logic                press_match;
  logic [FAIL_W-1:0]   fail_inc;

  assign press       = {U, Z};
  // Shifting left puts the next expected digit (MSB first) in the top bit.
  assign code_shift  = code_q << idx_q;
  assign exp_bit     = code_shift[CODE_LEN-1];
  assign press_match = ((press == PRESS_ONE) && exp_bit) ||
                       ((press == PRESS_ZERO) && !exp_bit);
  assign fail_inc    = fail_q + FAIL_W'(1);

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    idx_d        = idx_q;
    fail_d       = fail_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      ST_IDLE, ST_ENTER: begin
        // A load in IDLE consumes the cycle; a held press is seen next cycle.
        if ((state_q == ST_IDLE) && code_load) begin
          code_d = code_in;
        end else if (press != PRESS_NONE) begin
          if (press_match) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_BAD;
          end
        end
      end
      ST_RELEASE: begin
        if (press == PRESS_NONE) begin
          if (idx_q == IDX_W'(CODE_LEN)) begin
            state_d      = ST_OPEN;
            idx_d        = '0;
            fail_d       = '0;
            tmr_load     = 1'b1;
            tmr_load_val = CNT_W'(OPEN_CYCLES - 1);
          end else begin
            state_d = ST_ENTER;
          end
        end
      end
      ST_BAD: begin
        if (press == PRESS_NONE) begin
          idx_d  = '0;
          fail_d = fail_inc;
          if (fail_inc == FAIL_W'(MAX_FAILS)) begin
            state_d      = ST_LOCKOUT;
            tmr_load     = 1'b1;
            tmr_load_val = CNT_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OPEN: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      code_q  <= CODE_RESET;
      idx_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
    end
  end

  numlock_timer #(.WIDTH(CNT_W)) u_timer (
    .Clk      (Clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .done     (tmr_done),
    .count    (tmr_count_unused)
  );

  assign Unlock     = (state_q == ST_OPEN);
  assign Lockout    = (state_q == ST_LOCKOUT);
  assign q_state    = state_q;
  assign digit_idx  = idx_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_numlock_param_sm.sv
// Directed bench for numlock_param_sm: a cycle-by-cycle vector table on the
// default build plus hand sequences for reset corners and an 8-digit build.
module tb_numlock_param_sm;

  localparam logic [2:0] S_IDLE = 3'd0, S_ENTER = 3'd1, S_REL = 3'd2,
                         S_BAD = 3'd3, S_OPEN = 3'd4, S_LOCK = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, u, z, ld;
  logic [3:0] code;
  logic       unl, lck;
  logic [2:0] st;
  logic [2:0] idx;
  logic [1:0] fail;

  logic       rst2, u2, z2, ld2;
  logic [7:0] code2;
  logic       unl2, lck2;
  logic [2:0] st2;
  logic [3:0] idx2;
  logic [1:0] fail2;

  numlock_param_sm dut (
    .Clk(clk), .reset(rst), .U(u), .Z(z), .code_in(code), .code_load(ld),
    .Unlock(unl), .Lockout(lck), .q_state(st), .digit_idx(idx), .fail_count(fail)
  );

  numlock_param_sm #(
    .CODE_LEN(8), .CODE_RESET(8'b1100_1010), .OPEN_CYCLES(1)
  ) dut8 (
    .Clk(clk), .reset(rst2), .U(u2), .Z(z2), .code_in(code2), .code_load(ld2),
    .Unlock(unl2), .Lockout(lck2), .q_state(st2), .digit_idx(idx2), .fail_count(fail2)
  );

  typedef struct {
    logic       u, z, ld;
    logic [3:0] code;
    logic [2:0] st;
    logic [2:0] idx;
    logic [1:0] fail;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic uu, input logic zz, input logic l, input logic [3:0] c,
                     input logic [2:0] s, input int i, input int f);
    vec_t v;
    v.u = uu; v.z = zz; v.ld = l; v.code = c;
    v.st = s; v.idx = 3'(i); v.fail = 2'(f);
    tbl.push_back(v);
  endtask

  // Correct entry of c with releases; ends on the first OPEN cycle.
  task automatic add_entry(input logic [3:0] c, input int f);
    for (int i = 0; i < 4; i++) begin
      add(c[3-i], !c[3-i], 1'b0, 4'h0, S_REL, i + 1, f);
      if (i < 3) add(1'b0, 1'b0, 1'b0, 4'h0, S_ENTER, i + 1, f);
      else       add(1'b0, 1'b0, 1'b0, 4'h0, S_OPEN, 0, 0);
    end
  endtask

  // Remaining five OPEN cycles then back to IDLE.
  task automatic add_open_rest();
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 4'h0, S_OPEN, 0, 0);
    add(1'b0, 1'b0, 1'b0, 4'h0, S_IDLE, 0, 0);
  endtask

  task automatic enter1(input logic [3:0] c);
    for (int i = 3; i >= 0; i--) begin
      u = c[i]; z = !c[i]; step();
      u = 1'b0; z = 1'b0; step();
    end
  endtask

  task automatic enter2(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) begin
      u2 = c[i]; z2 = !c[i]; step();
      u2 = 1'b0; z2 = 1'b0; step();
    end
  endtask

  initial begin
    // Correct code 1011
    add_entry(4'b1011, 0);
    add_open_rest();
    // One bad attempt, held across BAD, then correct code clears fail_count
    add(1, 0, 0, 0, S_REL, 1, 0);
    add(0, 0, 0, 0, S_ENTER, 1, 0);
    add(1, 0, 0, 0, S_BAD, 1, 0);
    add(1, 0, 0, 0, S_BAD, 1, 0);
    add(0, 0, 0, 0, S_IDLE, 0, 1);
    add_entry(4'b1011, 1);
    add_open_rest();
    // Three bad attempts -> 16-cycle lockout, code entered during it ignored
    for (int a = 0; a < 3; a++) begin
      add(0, 1, 0, 0, S_BAD, 0, a);
      if (a < 2) add(0, 0, 0, 0, S_IDLE, 0, a + 1);
      else       add(0, 0, 0, 0, S_LOCK, 0, 3);
    end
    add(1, 0, 0, 0, S_LOCK, 0, 3); add(0, 0, 0, 0, S_LOCK, 0, 3);
    add(0, 1, 0, 0, S_LOCK, 0, 3); add(0, 0, 0, 0, S_LOCK, 0, 3);
    add(1, 0, 0, 0, S_LOCK, 0, 3); add(0, 0, 0, 0, S_LOCK, 0, 3);
    add(1, 0, 0, 0, S_LOCK, 0, 3); add(0, 0, 0, 0, S_LOCK, 0, 3);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, S_LOCK, 0, 3);
    add(0, 0, 0, 0, S_IDLE, 0, 0);
    add_entry(4'b1011, 0);
    add_open_rest();
    // Load 0110: 1011 now fails, 0110 opens; loads in OPEN/ENTER ignored
    add(0, 0, 1, 4'b0110, S_IDLE, 0, 0);
    add(1, 0, 0, 0, S_BAD, 0, 0);
    add(0, 0, 0, 0, S_IDLE, 0, 1);
    add_entry(4'b0110, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 4'b1011, S_OPEN, 0, 0);
    add(0, 0, 0, 0, S_IDLE, 0, 0);
    add(0, 1, 0, 0, S_REL, 1, 0);
    add(0, 0, 0, 0, S_ENTER, 1, 0);
    add(0, 0, 1, 4'b1011, S_ENTER, 1, 0);
    add(1, 0, 0, 0, S_REL, 2, 0);
    add(0, 0, 0, 0, S_ENTER, 2, 0);
    add(1, 0, 0, 0, S_REL, 3, 0);
    add(0, 0, 0, 0, S_ENTER, 3, 0);
    add(0, 1, 0, 0, S_REL, 4, 0);
    add(0, 0, 0, 0, S_OPEN, 0, 0);
    add_open_rest();
    // Load and press in the same IDLE cycle: load wins, press seen next cycle
    add(1, 0, 1, 4'b1011, S_IDLE, 0, 0);
    add(1, 0, 0, 0, S_REL, 1, 0);
    // 11 at digit_idx 2 -> BAD
    add(0, 0, 0, 0, S_ENTER, 1, 0);
    add(0, 1, 0, 0, S_REL, 2, 0);
    add(0, 0, 0, 0, S_ENTER, 2, 0);
    add(1, 1, 0, 0, S_BAD, 2, 0);
    add(0, 0, 0, 0, S_IDLE, 0, 1);
    // U held across OPEN exit is evaluated in IDLE right after
    add_entry(4'b1011, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, S_OPEN, 0, 0);
    add(1, 0, 0, 0, S_OPEN, 0, 0);
    add(1, 0, 0, 0, S_IDLE, 0, 0);
    add(1, 0, 0, 0, S_REL, 1, 0);
    add(0, 0, 0, 0, S_ENTER, 1, 0);

    rst = 1'b0; u = 1'b0; z = 1'b0; ld = 1'b0; code = 4'h0;
    rst2 = 1'b0; u2 = 1'b0; z2 = 1'b0; ld2 = 1'b0; code2 = 8'h00;
    step(); step();
    chk("reset state", st, S_IDLE);
    chk("reset idx", idx, 0);
    chk("reset fail", fail, 0);
    chk("reset unlock", unl, 0);
    chk("reset lockout", lck, 0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      u = tbl[i].u; z = tbl[i].z; ld = tbl[i].ld; code = tbl[i].code;
      step();
      chk($sformatf("row%0d state", i), st, tbl[i].st);
      chk($sformatf("row%0d idx", i), idx, tbl[i].idx);
      chk($sformatf("row%0d fail", i), fail, tbl[i].fail);
      chk($sformatf("row%0d unlock", i), unl, tbl[i].st == S_OPEN);
      chk($sformatf("row%0d lockout", i), lck, tbl[i].st == S_LOCK);
    end
    u = 1'b0; z = 1'b0; ld = 1'b0;

    // Reset dominates code_load
    rst = 1'b0; ld = 1'b1; code = 4'b0110;
    step();
    chk("rst+load state", st, S_IDLE);
    chk("rst+load idx", idx, 0);
    rst = 1'b1; ld = 1'b0;
    enter1(4'b1011);
    chk("rst beats load opens", st, S_OPEN);
    repeat (6) step();
    chk("open done idle", st, S_IDLE);

    // Reset in OPEN cycle 3 aborts and restores CODE_RESET
    ld = 1'b1; code = 4'b0110; step(); ld = 1'b0;
    enter1(4'b0110);
    chk("0110 opens", unl, 1);
    step(); step();
    chk("open cycle3", unl, 1);
    rst = 1'b0; step();
    chk("mid-open rst unlock", unl, 0);
    chk("mid-open rst state", st, S_IDLE);
    rst = 1'b1;
    enter1(4'b1011);
    chk("code back to reset", st, S_OPEN);

    // CODE_LEN=8, OPEN_CYCLES=1 build
    chk("dut8 reset state", st2, S_IDLE);
    chk("dut8 reset idx", idx2, 0);
    chk("dut8 reset fail", fail2, 0);
    rst2 = 1'b1; ld2 = 1'b1; code2 = 8'h0F; step(); ld2 = 1'b0;
    enter2(8'h0F);
    chk("dut8 loaded opens", unl2, 1);
    chk("dut8 open idx", idx2, 0);
    rst2 = 1'b0; ld2 = 1'b1; code2 = 8'h0F; step();
    chk("dut8 rst unlock", unl2, 0);
    chk("dut8 rst state", st2, S_IDLE);
    rst2 = 1'b1; ld2 = 1'b0;
    enter2(8'b1100_1010);
    chk("dut8 reset code opens", unl2, 1);
    step();
    chk("dut8 one-cycle open", unl2, 0);
    chk("dut8 back idle", st2, S_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/numlock_param_sm.md
# numlock_param_sm

Parametrised successor to the fixed 1011 two-button number lock: a combination lock of CODE_LEN button presses (U = 1, Z = 0). The code is loadable at run time, the unlock hold time is configurable, and repeated wrong entries trigger a timed lockout. It sits between the debounced/single-clocked button inputs and the door actuator (Unlock) and status display (state, digit index, fail count).

## Interface
- CODE_LEN, 4: number of presses in the code (2..16).
- CODE_RESET, 4'b1011: code after reset, CODE_LEN bits, MSB entered first.
- OPEN_CYCLES, 6: cycles Unlock is held (≥1).
- MAX_FAILS, 3: consecutive failed attempts that cause lockout (≥1).
- LOCKOUT_CYCLES, 16: cycles Lockout is held (≥1).
- Clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- U  in  1  "1" button, level, debounced, synchronous to Clk.
- Z  in  1  "0" button, level, debounced, synchronous to Clk.
- code_in  in  CODE_LEN  new code, MSB entered first.
- code_load  in  1  latch code_in (honoured only in IDLE).
- Unlock  out  1  door open.
- Lockout  out  1  lockout active.
- q_state  out  3  encoded current state.
- digit_idx  out  clog2(CODE_LEN+1)  presses accepted so far.
- fail_count  out  clog2(MAX_FAILS+1)  consecutive failures.

## Operation
- Press decode on {U,Z}: 10 = digit 1; 01 = digit 0; 11 = invalid (always a mismatch); 00 = no press.
- Expected digit = code_reg[CODE_LEN-1-digit_idx].
- States: IDLE(0), ENTER(1), RELEASE(2), BAD(3), OPEN(4), LOCKOUT(5).
- IDLE / ENTER:
  - No press: hold state.
  - Matching press: digit_idx+1, go to RELEASE.
  - Mismatch or 11: go to BAD.
  - IDLE is ENTER with digit_idx = 0.
- RELEASE: wait for {U,Z} = 00.
  - digit_idx = CODE_LEN: go to OPEN.
  - Otherwise: go to ENTER.
- OPEN:
  - On entry: fail_count←0, digit_idx←0.
  - Hold OPEN_CYCLES cycles, then go to IDLE. Inputs ignored.
- BAD: wait for {U,Z} = 00, then digit_idx←0.
  - fail_count+1 = MAX_FAILS: go to LOCKOUT.
  - Otherwise: fail_count+1, go to IDLE.
- LOCKOUT:
  - Hold LOCKOUT_CYCLES cycles, inputs ignored, fail_count held at MAX_FAILS.
  - On exit: fail_count←0, go to IDLE.
- code_load: in IDLE, code_reg←code_in. Ignored in every other state.
  - If a press is present in the same cycle, the load wins and the press is not evaluated that cycle. The still-held level is evaluated next cycle against the new code.
- Unlock = (state = OPEN); Lockout = (state = LOCKOUT). Both decoded from the state register only, no input path.

## Timing
- Reset (reset = 0 at an edge): state IDLE, code_reg = CODE_RESET, digit_idx 0, fail_count 0, timer 0, Unlock 0, Lockout 0, q_state 0.
  - Reset mid-OPEN or mid-LOCKOUT aborts at that edge.
  - Reset dominates code_load.
- A press sampled at edge t changes state at edge t (visible from t+1). One state step per cycle.
- Final release sampled at edge t: Unlock high for cycles t+1 .. t+OPEN_CYCLES exactly, low in cycle t+OPEN_CYCLES+1 (state IDLE).
- Timer:
  - Loaded with N-1 on entry to OPEN/LOCKOUT, decrements each cycle.
  - State exits when the timer is 0, so dwell is exactly N cycles.
  - Width clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)).
- A button held across OPEN or LOCKOUT exit is evaluated in IDLE on the first cycle after exit.
- No press is ever counted twice: a press is only accepted from IDLE/ENTER, and RELEASE blocks until both buttons are up.

## Structure
- Package numlock_pkg: state localparams (3-bit encoding above), press-decode constants (PRESS_NONE/ONE/ZERO/BAD), clog2 helper.
- Sub-module numlock_timer (parameter WIDTH; ports load, load_val, done, count; synchronous active-low reset). Instantiated once, shared by OPEN and LOCKOUT.
- The FSM, code register, digit_idx and fail_count live in numlock_param_sm.

## Test plan
- Reset, press 1,0,1,1 with releases → Unlock high exactly 6 cycles after the last release edge, then IDLE, fail_count 0.
- Press 1 then 1 (code 1011) → BAD. Release → IDLE, fail_count 1. Correct code next → Unlock, fail_count 0.
- Three bad attempts → Lockout high exactly 16 cycles. Correct code entered during lockout is ignored. After exit, fail_count 0 and the correct code opens.
- code_load = 1 with code_in = 4'b0110 in IDLE → 1011 now fails, 0110 opens. code_load during ENTER or OPEN → no change.
- Press U and Z together (11) in ENTER at digit_idx 2 → BAD. Hold U across the OPEN exit → evaluated in IDLE on the first cycle after exit.
- Assert reset during OPEN at cycle 3 → Unlock 0 and q_state 0 next cycle, code_reg = CODE_RESET. Repeat with CODE_LEN = 8, OPEN_CYCLES = 1.
